// File: rtl/reaction_timer_pkg.sv
// rtl/reaction_timer_pkg.sv - shared encodings, constants and defaults for the reaction timer
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } delayState_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_MIN_DELAY_MS = 1000;
  localparam int DEF_RAND_BITS    = 11;
  localparam int DEF_SCORE_W      = 13;

  // Bits needed to hold the longest possible delay in ms.
  function automatic int remWidth(input int minMs, input int randBits);
    return $clog2(minMs + (1 << randBits));
  endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// rtl/reaction_timer_if.sv - handshake bundle between the game controller and the reaction timer
interface reaction_timer_if #(parameter int SCORE_W = 13);

  logic               delayCounterEnable;
  logic               scoreCounterEnable;
  logic               scoreClear;
  logic               delayCounterDone;
  logic [SCORE_W-1:0] scoreCounter;
  logic               scoreSaturated;
  logic               msTick;

  modport master (
    output delayCounterEnable, scoreCounterEnable, scoreClear,
    input  delayCounterDone, scoreCounter, scoreSaturated, msTick
  );

  modport slave (
    input  delayCounterEnable, scoreCounterEnable, scoreClear,
    output delayCounterDone, scoreCounter, scoreSaturated, msTick
  );

endinterface

// File: rtl/reaction_timer_lfsr16.sv
// rtl/reaction_timer_lfsr16.sv - free-running 16-bit Galois LFSR, reset to the fixed seed
module lfsr16
  import reaction_timer_pkg::*;
(
  input  logic        Clock,
  input  logic        CLRN,
  output logic [15:0] q
);

  // Right-shifting Galois form; a non-zero seed keeps it off the all-zero lockup state.
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      q <= LFSR_SEED;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - random wait delay and millisecond reaction score for the game controller
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int RAND_BITS    = DEF_RAND_BITS,
  parameter int SCORE_W      = DEF_SCORE_W
) (
  input logic               Clock,
  input logic               CLRN,
  reaction_timer_if.slave   bus
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int REM_W = remWidth(MIN_DELAY_MS, RAND_BITS);

  logic [PRE_W-1:0]   prescaler;
  logic               scoreEnPrev;
  logic [15:0]        lfsr;
  delayState_t        state, stateNext;
  logic [REM_W-1:0]   remaining;
  logic               leaveIdle, loadRemaining, decRemaining, doneNext;
  logic               scoreRise;
  logic [SCORE_W-1:0] scoreNext;

  lfsr16 uLfsr (
    .Clock (Clock),
    .CLRN  (CLRN),
    .q     (lfsr)
  );

  assign bus.msTick = (prescaler == PRE_W'(TICK_DIV - 1));
  assign scoreRise  = bus.scoreCounterEnable & ~scoreEnPrev;

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Abort (enable low) wins over a final tick landing on the same edge.
  always_comb begin
    stateNext = state;
    case (state)
      COUNT: begin
        if (!bus.delayCounterEnable) begin
          stateNext = IDLE;
        end else if (bus.msTick && remaining == REM_W'(1)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (!bus.delayCounterEnable) begin
          stateNext = IDLE;
        end
      end
      default: begin
        if (bus.delayCounterEnable) begin
          stateNext = COUNT;
        end
      end
    endcase
  end

  always_comb begin
    leaveIdle     = (state != COUNT) && (state != DONE) && (stateNext == COUNT);
    loadRemaining = leaveIdle;
    decRemaining  = (state == COUNT) && (stateNext == COUNT) && bus.msTick;
    doneNext      = (stateNext == DONE);
  end

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      remaining            <= '0;
      bus.delayCounterDone <= 1'b0;
    end else begin
      bus.delayCounterDone <= doneNext;
      if (loadRemaining) begin
        remaining <= REM_W'(MIN_DELAY_MS) + REM_W'(lfsr[RAND_BITS-1:0]);
      end else if (decRemaining) begin
        remaining <= remaining - REM_W'(1);
      end
    end
  end

  // A restart from either side realigns the tick so the first one lands TICK_DIV cycles later.
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      prescaler   <= '0;
      scoreEnPrev <= 1'b0;
    end else begin
      scoreEnPrev <= bus.scoreCounterEnable;
      if (leaveIdle || scoreRise || bus.msTick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  always_comb begin
    scoreNext = bus.scoreCounter;
    if (bus.scoreClear) begin
      scoreNext = '0;
    end else if (bus.scoreCounterEnable && bus.msTick && !bus.scoreSaturated) begin
      scoreNext = bus.scoreCounter + SCORE_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      bus.scoreCounter   <= '0;
      bus.scoreSaturated <= 1'b0;
    end else begin
      bus.scoreCounter   <= scoreNext;
      bus.scoreSaturated <= (scoreNext == '1);
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - directed vector table, corner sequences and randomized model comparison
module tb_reaction_timer;
  import reaction_timer_pkg::*;

  localparam int TD    = 4;
  localparam int MINMS = 2;
  localparam int RB    = 3;
  localparam int SMAX  = 8191;

  logic Clock = 1'b0;
  logic CLRN  = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 Clock = ~Clock;

  reaction_timer_if #(.SCORE_W(13)) busA ();
  reaction_timer_if #(.SCORE_W(4))  busB ();

  reaction_timer #(.TICK_DIV(TD), .MIN_DELAY_MS(MINMS), .RAND_BITS(RB), .SCORE_W(13)) dut (
    .Clock (Clock),
    .CLRN  (CLRN),
    .bus   (busA)
  );

  reaction_timer #(.TICK_DIV(2), .MIN_DELAY_MS(MINMS), .RAND_BITS(RB), .SCORE_W(4)) dutSat (
    .Clock (Clock),
    .CLRN  (CLRN),
    .bus   (busB)
  );

  // Reference: a waiting/done flag pair with a ms countdown, plain integer arithmetic.
  int  mPre, mRem, mScore;
  int  mLfsr;
  bit  mWaiting, mDone, mEnPrev;

  always @(posedge Clock or negedge CLRN) begin
    bit tick, restart, rise;
    if (!CLRN) begin
      mPre = 0; mLfsr = 'hACE1; mWaiting = 0; mDone = 0; mRem = 0; mScore = 0; mEnPrev = 0;
    end else begin
      tick    = (mPre == TD - 1);
      restart = 0;
      if (mWaiting) begin
        if (!busA.delayCounterEnable) mWaiting = 0;
        else if (tick) begin
          if (mRem == 1) begin mWaiting = 0; mDone = 1; end
          else mRem = mRem - 1;
        end
      end else if (mDone) begin
        if (!busA.delayCounterEnable) mDone = 0;
      end else if (busA.delayCounterEnable) begin
        mRem = MINMS + (mLfsr % (1 << RB));
        mWaiting = 1;
        restart = 1;
      end
      if (busA.scoreClear) mScore = 0;
      else if (busA.scoreCounterEnable && tick && mScore < SMAX) mScore = mScore + 1;
      rise    = busA.scoreCounterEnable && !mEnPrev;
      mEnPrev = busA.scoreCounterEnable;
      mPre    = (restart || rise || tick) ? 0 : mPre + 1;
      mLfsr   = (mLfsr >> 1) ^ ((mLfsr & 1) ? 'hB400 : 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic stepN(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  typedef struct {
    bit dEn; bit sEn; bit clr; int cycles;
    bit expDone; int expScore; bit expTick;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1, 0, 0, 12, 0,  0, 1},   // delay 3 ms: not done after 11 edges past start
      '{1, 0, 0,  1, 1,  0, 0},   // third tick lands on edge 12 past start
      '{1, 0, 0,  3, 1,  0, 1},   // done holds while enable stays high
      '{0, 0, 0,  1, 0,  0, 0},   // enable dropped: done clears next edge
      '{1, 0, 0,  6, 0,  0, 0},   // restart then abort
      '{0, 0, 0, 40, 0,  0, 0},   // aborted delay never completes
      '{0, 1, 0, 41, 0, 10, 0},   // ticks at 4..40 past score start
      '{0, 0, 0,  5, 0, 10, 0},   // score holds after enable falls
      '{0, 0, 1,  1, 0,  0, 0},   // clear
      '{0, 0, 0,  1, 0,  0, 1},
      '{0, 1, 0,  4, 0,  1, 1},   // restart edge coincides with a tick
      '{0, 1, 1,  1, 0,  0, 0},   // clear beats tick+enable
      '{0, 0, 0,  1, 0,  0, 0}
    };

    busA.delayCounterEnable = 1; busA.scoreCounterEnable = 1; busA.scoreClear = 1;
    busB.delayCounterEnable = 1; busB.scoreCounterEnable = 1; busB.scoreClear = 1;
    CLRN = 0;
    stepN(3);
    check("rst_done", busA.delayCounterDone, 0);
    check("rst_score", busA.scoreCounter, 0);
    check("rst_sat", busA.scoreSaturated, 0);
    check("rst_tick", busA.msTick, 0);
    check("rst_lfsr", dut.lfsr, 16'hACE1);
    check("rst_sat_score", busB.scoreCounter, 0);

    busA.scoreCounterEnable = 0; busA.scoreClear = 0;
    busB.delayCounterEnable = 0; busB.scoreCounterEnable = 0; busB.scoreClear = 0;
    CLRN = 1;
    #1;
    check("release_idle", 32'(dut.state), 32'(IDLE));
    #1;

    foreach (vecs[i]) begin
      busA.delayCounterEnable = vecs[i].dEn;
      busA.scoreCounterEnable = vecs[i].sEn;
      busA.scoreClear         = vecs[i].clr;
      stepN(vecs[i].cycles);
      check($sformatf("vec%0d_done", i), busA.delayCounterDone, vecs[i].expDone);
      check($sformatf("vec%0d_score", i), busA.scoreCounter, vecs[i].expScore);
      check($sformatf("vec%0d_sat", i), busA.scoreSaturated, 0);
      check($sformatf("vec%0d_tick", i), busA.msTick, vecs[i].expTick);
    end

    // Reset in the middle of a running delay, then a fresh delay from the reseeded LFSR.
    busA.delayCounterEnable = 1; busA.scoreCounterEnable = 1;
    stepN(6);
    check("midcount_score", busA.scoreCounter, 1);
    check("midcount_state", 32'(dut.state), 32'(COUNT));
    CLRN = 0;
    #1;
    check("async_done", busA.delayCounterDone, 0);
    check("async_score", busA.scoreCounter, 0);
    check("async_state", 32'(dut.state), 32'(IDLE));
    stepN(2);
    busA.scoreCounterEnable = 0;
    CLRN = 1;
    stepN(12);
    check("reseed_not_yet", busA.delayCounterDone, 0);
    stepN(1);
    check("reseed_done", busA.delayCounterDone, 1);
    busA.delayCounterEnable = 0;
    stepN(1);
    check("reseed_done_fall", busA.delayCounterDone, 0);

    // Saturation on the narrow instance.
    busB.scoreCounterEnable = 1;
    stepN(40);
    check("sat_score", busB.scoreCounter, 15);
    check("sat_flag", busB.scoreSaturated, 1);
    busB.scoreCounterEnable = 0;
    stepN(2);
    check("sat_hold", busB.scoreCounter, 15);
    busB.scoreClear = 1;
    stepN(1);
    busB.scoreClear = 0;
    check("sat_clr_score", busB.scoreCounter, 0);
    check("sat_clr_flag", busB.scoreSaturated, 0);

    // Random controller-like traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if (!CLRN) CLRN = 1;
      else if ($urandom_range(0, 999) < 2) CLRN = 0;
      if ($urandom_range(0, 99) < 5) busA.delayCounterEnable = ~busA.delayCounterEnable;
      if (busA.delayCounterDone && $urandom_range(0, 1) == 1) busA.delayCounterEnable = 0;
      if ($urandom_range(0, 99) < 4) busA.scoreCounterEnable = ~busA.scoreCounterEnable;
      busA.scoreClear = ($urandom_range(0, 99) < 2);
      stepN(1);
      check("rnd_done", busA.delayCounterDone, 32'(mDone));
      check("rnd_score", busA.scoreCounter, mScore);
      check("rnd_sat", busA.scoreSaturated, 32'(mScore == SMAX));
      check("rnd_tick", busA.msTick, 32'(mPre == TD - 1));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Timing front-end for the reaction-time game controller.
- Generates the pseudo-random "wait before green" delay and asserts delayCounterDone when it expires.
- Counts the player's reaction time in milliseconds on scoreCounter.
- Both outputs feed the game state machine directly; it drives delayCounterEnable, scoreCounterEnable and scoreClear back into this block.

Parameters:
- TICK_DIV, 50000, Clock cycles per millisecond tick (>= 2).
- MIN_DELAY_MS, 1000, fixed part of the random delay, in ms.
- RAND_BITS, 11, number of LFSR bits added to MIN_DELAY_MS (random part 0..2^RAND_BITS-1 ms).
- SCORE_W, 13, score width; the score saturates at 2^SCORE_W-1.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- CLRN  in  1  asynchronous active-low reset.
- delayCounterEnable  in  1  held high by the controller while it waits for the delay.
- scoreCounterEnable  in  1  high while the green LED is lit and reaction time accrues.
- scoreClear  in  1  synchronous clear of the score.
- delayCounterDone  out  1  registered; high when the random delay has elapsed.
- scoreCounter  out  SCORE_W  registered reaction time in ms.
- scoreSaturated  out  1  registered; high when scoreCounter = 2^SCORE_W-1.
- msTick  out  1  combinational; high in the cycle where prescaler = TICK_DIV-1.

Behaviour:
- Reset (CLRN=0, asynchronous):
  - prescaler=0, lfsr=16'hACE1, delay FSM=IDLE, remaining=0.
  - delayCounterDone=0, scoreCounter=0, scoreSaturated=0.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps to 0.
  - Forced to 0 on the edge where the delay FSM leaves IDLE, or where scoreCounterEnable rises (edge-detect register, reset 0). This makes the first tick exactly TICK_DIV cycles after the start.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (taps mask 16'hB400).
  - Advances every clock and never holds 0.
  - The delay uses the pre-advance value present at the sampling edge.
- Delay FSM, 2-bit, states IDLE=0, COUNT=1, DONE=2:
  - IDLE: delayCounterDone=0. If delayCounterEnable=1: remaining <= MIN_DELAY_MS + lfsr[RAND_BITS-1:0], then go to COUNT.
  - COUNT: if delayCounterEnable=0, go to IDLE (abort; done never asserts). Otherwise, on msTick: if remaining==1, go to DONE and set delayCounterDone<=1; else remaining <= remaining-1.
  - DONE: delayCounterDone=1. Go to IDLE (done <= 0) on the first edge where delayCounterEnable=0. The controller gates its enable with done, so done is high for at least one full cycle.
  - Encoding 3 is unreachable and decodes to IDLE.
  - Abort takes priority over a coincident final tick.
- remaining width: enough bits to hold MIN_DELAY_MS + 2^RAND_BITS - 1 (12 bits at defaults).
- Score, evaluated on each edge in this priority order:
  - scoreClear=1: score <= 0.
  - Else if scoreCounterEnable & msTick & ~scoreSaturated: score <= score+1.
  - Otherwise hold.
  - scoreSaturated is registered and equals (next score == all ones).
  - No wrap: the score holds at 8191 at the default width.
- Delay logic and score logic are independent. Both may be enabled at once; they share the prescaler, and a restart from either side resets it.

Decomposition:
- Shared package/header holds:
  - delay FSM state encodings IDLE/COUNT/DONE;
  - LFSR_SEED = 16'hACE1 and LFSR_TAPS = 16'hB400;
  - the default TICK_DIV, MIN_DELAY_MS and RAND_BITS.
- One sub-module: lfsr16 (Clock, CLRN, q[15:0]), free-running with async reset to the seed.
- The prescaler, delay FSM and score counter stay inline.

Test Plan (TICK_DIV=4, MIN_DELAY_MS=2, RAND_BITS=3 unless stated):
1. Reset: hold CLRN=0 for 3 cycles with all inputs high -> every output 0 and lfsr=16'hACE1. Release CLRN -> state stays IDLE until the first edge.
2. Delay nominal: release CLRN with delayCounterEnable=1 at the first edge -> captured seed low bits 3'b001, delay=3 ms. delayCounterDone rises after edge 12 (ticks at edges 4, 8, 12). Controller drops enable -> done falls on the next edge.
3. Abort: enable high for 6 cycles, then low -> FSM returns to IDLE and delayCounterDone stays 0 for 40 further cycles.
4. Score count: scoreCounterEnable high for exactly 40 cycles -> scoreCounter=10 and holds after enable falls. Pulse scoreClear -> 0 on the next edge.
5. Saturation (TICK_DIV=2, SCORE_W=4): enable for 40 cycles -> score stops at 15 and scoreSaturated=1. Clear -> score=0 and scoreSaturated=0.
6. Collisions and reset:
   - scoreClear coincident with msTick and enable -> score=0.
   - CLRN pulse low mid-COUNT -> immediate IDLE, done=0, score=0.
   - Re-enable -> the new delay is computed from the reseeded LFSR.
